// File: rtl/fft_frame_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_sched_pkg
//  Purpose  : Shared constants, channel tags and FSM encoding for the V/I
//             FFT frame scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package fft_frame_sched_pkg;

    localparam int LGN_DFLT = 8;
    localparam int FRAME_N  = 1 << LGN_DFLT;
    localparam int FRAME_2N = 2 * FRAME_N;

    localparam logic CHAN_V = 1'b0;
    localparam logic CHAN_I = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CAPTURE = 3'd1;
    localparam state_t ST_RST_FFT = 3'd2;
    localparam state_t ST_FEED_V  = 3'd3;
    localparam state_t ST_FEED_I  = 3'd4;
    localparam state_t ST_FLUSH   = 3'd5;
    localparam state_t ST_DONE    = 3'd6;

endpackage
`default_nettype wire

// File: rtl/fft_frame_sched_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_buf
//  Purpose  : Simple dual-port frame RAM, one write port and one read port
//             with a single registered read stage.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_frame_buf
    import fft_frame_sched_pkg::*;
#(
    parameter int AW = LGN_DFLT,
    parameter int DW = 20
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        rdata_q <= mem[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fft_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_sched
//  Purpose  : Captures simultaneous V/I frames, streams them back-to-back
//             through one shared FFT core and returns channel-tagged bins.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_frame_sched
    import fft_frame_sched_pkg::*;
#(
    parameter int IW      = 10,
    parameter int OW      = 15,
    parameter int LGN     = LGN_DFLT,
    parameter int TIMEOUT = 2048
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_adc_valid,
    input  logic [2*IW-1:0] i_v_sample,
    input  logic [2*IW-1:0] i_i_sample,
    output logic            o_fft_reset,
    output logic            o_fft_ce,
    output logic [2*IW-1:0] o_fft_sample,
    input  logic [2*OW-1:0] i_fft_result,
    input  logic            i_fft_sync,
    output logic            o_bin_valid,
    output logic            o_bin_chan,
    output logic [LGN-1:0]  o_bin_idx,
    output logic [2*OW-1:0] o_bin_data,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam int N  = 1 << LGN;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [LGN+1:0] CNT_N     = (LGN+2)'(N);
    localparam logic [LGN+1:0] CNT_2N    = (LGN+2)'(2 * N);
    localparam logic [TW-1:0]  TCNT_LAST = TW'(TIMEOUT - 1);

    state_t          state_q,     state_d;
    logic [LGN-1:0]  wc_q,        wc_d;
    logic            rst_cnt_q,   rst_cnt_d;
    logic [LGN-1:0]  fc_q,        fc_d;
    logic [LGN+1:0]  iss_q,       iss_d;
    logic            rd_valid_q,  rd_valid_d;
    logic            rd_chan_q,   rd_chan_d;
    logic [2*IW-1:0] sample_q,    sample_d;
    logic [TW-1:0]   tcnt_q,      tcnt_d;
    logic            started_q,   started_d;
    logic [LGN+1:0]  ocnt_q,      ocnt_d;
    logic            bin_valid_q, bin_valid_d;
    logic            bin_chan_q,  bin_chan_d;
    logic [LGN-1:0]  bin_idx_q,   bin_idx_d;
    logic [2*OW-1:0] bin_data_q,  bin_data_d;
    logic            err_q,       err_d;

    logic [2*IW-1:0] w_v_rdata;
    logic [2*IW-1:0] w_i_rdata;
    logic            w_cap_we;
    logic            w_streaming;
    logic            w_feeding;
    logic            w_issue;
    logic            w_all_bins;
    logic            w_sync_err;
    logic            w_timed_out;
    logic            w_abort;
    logic            w_capture_bin;

    fft_frame_buf #(
        .AW (LGN),
        .DW (2*IW)
    ) u_buf_v (
        .i_clk   (i_clk),
        .i_we    (w_cap_we),
        .i_waddr (wc_q),
        .i_wdata (i_v_sample),
        .i_raddr (iss_q[LGN-1:0]),
        .o_rdata (w_v_rdata)
    );

    fft_frame_buf #(
        .AW (LGN),
        .DW (2*IW)
    ) u_buf_i (
        .i_clk   (i_clk),
        .i_we    (w_cap_we),
        .i_waddr (wc_q),
        .i_wdata (i_i_sample),
        .i_raddr (iss_q[LGN-1:0]),
        .o_rdata (w_i_rdata)
    );

    always_comb begin
        w_cap_we    = (state_q == ST_CAPTURE) && i_adc_valid;
        w_streaming = state_q inside {ST_RST_FFT, ST_FEED_V, ST_FEED_I, ST_FLUSH};
        w_feeding   = state_q inside {ST_FEED_V, ST_FEED_I, ST_FLUSH};
        // Reads start in RST_FFT so that the RAM and sample register latency
        // is hidden behind the core reset.
        w_issue     = (state_q inside {ST_RST_FFT, ST_FEED_V, ST_FEED_I}) && (iss_q < CNT_2N);
        w_all_bins  = w_feeding && started_q && (ocnt_q == CNT_2N);
        w_sync_err  = w_feeding && started_q && i_fft_sync
                      && (ocnt_q != CNT_N) && (ocnt_q < CNT_2N);
        w_timed_out = w_feeding && (tcnt_q == TCNT_LAST);
        w_abort     = !w_all_bins && (w_sync_err || w_timed_out);
        w_capture_bin = w_feeding && !w_abort
                        && (started_q ? (ocnt_q < CNT_2N) : i_fft_sync);
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (i_adc_valid && (wc_q == '1)) begin
                    state_d = ST_RST_FFT;
                end
            end
            ST_RST_FFT: begin
                if (rst_cnt_q) begin
                    state_d = ST_FEED_V;
                end
            end
            ST_FEED_V, ST_FEED_I, ST_FLUSH: begin
                if (w_all_bins) begin
                    state_d = ST_DONE;
                end else if (w_abort) begin
                    state_d = ST_IDLE;
                end else if ((state_q == ST_FEED_V) && (fc_q == '1)) begin
                    state_d = ST_FEED_I;
                end else if ((state_q == ST_FEED_I) && (fc_q == '1)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_fft_reset = (state_q == ST_RST_FFT);
        o_fft_ce    = w_streaming;
        o_busy      = (state_q != ST_IDLE);
        o_done      = (state_q == ST_DONE);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        wc_d = wc_q;
        if (state_q == ST_IDLE) begin
            wc_d = '0;
        end else if (w_cap_we) begin
            wc_d = wc_q + 1'b1;
        end

        rst_cnt_d = (state_q == ST_RST_FFT) ? ~rst_cnt_q : 1'b0;
        fc_d      = (state_q inside {ST_FEED_V, ST_FEED_I}) ? fc_q + 1'b1 : '0;

        iss_d = '0;
        if (state_q inside {ST_RST_FFT, ST_FEED_V, ST_FEED_I}) begin
            iss_d = w_issue ? iss_q + 1'b1 : iss_q;
        end
        rd_valid_d = w_issue;
        rd_chan_d  = (iss_q >= CNT_N) ? CHAN_I : CHAN_V;

        // Once all reads are issued the core is flushed with zeros.
        sample_d = '0;
        if (w_streaming && rd_valid_q) begin
            sample_d = (rd_chan_q == CHAN_I) ? w_i_rdata : w_v_rdata;
        end

        tcnt_d    = w_feeding ? tcnt_q + 1'b1 : '0;
        started_d = w_feeding && !w_abort && (started_q || i_fft_sync);
        ocnt_d    = '0;
        if (w_feeding) begin
            ocnt_d = w_capture_bin ? ocnt_q + 1'b1 : ocnt_q;
        end

        bin_valid_d = w_capture_bin;
        bin_chan_d  = w_capture_bin && (ocnt_q >= CNT_N);
        bin_idx_d   = w_capture_bin ? ocnt_q[LGN-1:0] : '0;
        bin_data_d  = w_capture_bin ? i_fft_result : '0;

        err_d = err_q;
        if ((state_q == ST_IDLE) && i_start) begin
            err_d = 1'b0;
        end else if (w_feeding && w_abort) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wc_q        <= '0;
            rst_cnt_q   <= 1'b0;
            fc_q        <= '0;
            iss_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_chan_q   <= CHAN_V;
            sample_q    <= '0;
            tcnt_q      <= '0;
            started_q   <= 1'b0;
            ocnt_q      <= '0;
            bin_valid_q <= 1'b0;
            bin_chan_q  <= CHAN_V;
            bin_idx_q   <= '0;
            bin_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            wc_q        <= wc_d;
            rst_cnt_q   <= rst_cnt_d;
            fc_q        <= fc_d;
            iss_q       <= iss_d;
            rd_valid_q  <= rd_valid_d;
            rd_chan_q   <= rd_chan_d;
            sample_q    <= sample_d;
            tcnt_q      <= tcnt_d;
            started_q   <= started_d;
            ocnt_q      <= ocnt_d;
            bin_valid_q <= bin_valid_d;
            bin_chan_q  <= bin_chan_d;
            bin_idx_q   <= bin_idx_d;
            bin_data_q  <= bin_data_d;
            err_q       <= err_d;
        end
    end

    assign o_fft_sample = sample_q;
    assign o_bin_valid  = bin_valid_q;
    assign o_bin_chan   = bin_chan_q;
    assign o_bin_idx    = bin_idx_q;
    assign o_bin_data   = bin_data_q;
    assign o_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_frame_sched
//  Purpose  : Directed self-checking bench; the FFT core is stood in for by an
//             identity transform with fixed latency so every bin is predictable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sched;
    import fft_frame_sched_pkg::*;

    localparam int IW  = 10;
    localparam int OW  = 15;
    localparam int LAT = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            adc_valid;
    logic [2*IW-1:0] v_sample;
    logic [2*IW-1:0] i_sample;
    logic            fft_reset;
    logic            fft_ce;
    logic [2*IW-1:0] fft_sample;
    logic [2*OW-1:0] fft_result;
    logic            fft_sync;
    logic            bin_valid;
    logic            bin_chan;
    logic [7:0]      bin_idx;
    logic [2*OW-1:0] bin_data;
    logic            busy;
    logic            done;
    logic            err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    fft_frame_sched #(.IW(IW), .OW(OW), .LGN(8), .TIMEOUT(2048)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_adc_valid  (adc_valid),
        .i_v_sample   (v_sample),
        .i_i_sample   (i_sample),
        .o_fft_reset  (fft_reset),
        .o_fft_ce     (fft_ce),
        .o_fft_sample (fft_sample),
        .i_fft_result (fft_result),
        .i_fft_sync   (fft_sync),
        .o_bin_valid  (bin_valid),
        .o_bin_chan   (bin_chan),
        .o_bin_idx    (bin_idx),
        .o_bin_data   (bin_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*OW-1:0] widen(input logic [2*IW-1:0] s);
        return {{(OW-IW){s[2*IW-1]}}, s[2*IW-1:IW], {(OW-IW){s[IW-1]}}, s[IW-1:0]};
    endfunction

    // ---------------------------------------------- core stand-in
    logic            force_sync_low = 1'b0;
    logic            pv [LAT];
    logic [15:0]     pk [LAT];
    logic [2*IW-1:0] pd [LAT];
    logic [15:0]     kcnt;

    always @(posedge clk) begin
        if (rst || (fft_ce && fft_reset)) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
            kcnt <= '0;
        end else if (fft_ce) begin
            pv[0] <= 1'b1;
            pk[0] <= kcnt;
            pd[0] <= fft_sample;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pk[i] <= pk[i-1];
                pd[i] <= pd[i-1];
            end
            kcnt <= kcnt + 16'd1;
        end
    end

    assign fft_result = pv[LAT-1] ? widen(pd[LAT-1]) : '0;
    assign fft_sync   = pv[LAT-1] && (pk[LAT-1][7:0] == 8'd0) && !force_sync_low;

    // ---------------------------------------------- output monitor
    logic            b_chan [600];
    logic [7:0]      b_idx  [600];
    logic [2*OW-1:0] b_data [600];
    int bin_cnt, first_bin_cyc, last_bin_cyc, ce_cnt, first_ce_cyc, feed_cyc;
    int cap_cnt, done_cnt, done_cyc;
    bit seen_ce, seen_feed;

    logic [2*IW-1:0] exp_v [FRAME_N];
    logic [2*IW-1:0] exp_i [FRAME_N];

    always @(negedge clk) begin
        if (bin_valid) begin
            if (bin_cnt < 600) begin
                b_chan[bin_cnt] = bin_chan;
                b_idx[bin_cnt]  = bin_idx;
                b_data[bin_cnt] = bin_data;
            end
            if (bin_cnt == 0) first_bin_cyc = cyc;
            last_bin_cyc = cyc;
            bin_cnt++;
        end
        if (fft_ce) begin
            ce_cnt++;
            if (!seen_ce) begin
                seen_ce      = 1'b1;
                first_ce_cyc = cyc;
            end
        end
        if (fft_ce && !fft_reset && !seen_feed) begin
            seen_feed = 1'b1;
            feed_cyc  = cyc;
        end
        if (busy && !fft_ce && !done) cap_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        bin_cnt = 0; first_bin_cyc = 0; last_bin_cyc = 0; ce_cnt = 0; first_ce_cyc = 0;
        feed_cyc = 0; cap_cnt = 0; done_cnt = 0; done_cyc = 0; seen_ce = 0; seen_feed = 0;
        for (int n = 0; n < 600; n++) begin
            b_chan[n] = 1'b0;
            b_idx[n]  = '0;
            b_data[n] = '1;
        end
    endtask

    function automatic int count_bad_bins();
        int bad;
        logic [2*IW-1:0] s;
        logic            ch;
        logic [7:0]      ix;
        bad = 0;
        for (int n = 0; n < FRAME_2N; n++) begin
            s  = (n < FRAME_N) ? exp_v[n] : exp_i[n - FRAME_N];
            ch = (n >= FRAME_N);
            ix = 8'(n % FRAME_N);
            if (b_chan[n] !== ch || b_idx[n] !== ix || b_data[n] !== widen(s)) bad++;
        end
        return bad;
    endfunction

    // ---------------------------------------------- stimulus helpers
    function automatic logic [2*IW-1:0] gen(input int pat, input int ch, input int k);
        logic [IW-1:0] re, im;
        case (pat)
            0: begin re = (ch == 0) ? 10'd100 : 10'd50; im = 10'd0; end
            1: begin
                re = (ch == 0) ? 10'(k * 3) : 10'(k * 7 + 5);
                im = (ch == 0) ? 10'(1023 - k) : (10'(k) ^ 10'h155);
            end
            2: begin re = 10'($urandom); im = 10'($urandom); end
            default: begin re = 10'h3AA; im = 10'h155; end
        endcase
        return {re, im};
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic capture(input int pat, input int duty, input int extra, input bit glitch);
        for (int k = 0; k < FRAME_N; k++) begin
            exp_v[k]  = gen(pat, 0, k);
            exp_i[k]  = gen(pat, 1, k);
            v_sample  = exp_v[k];
            i_sample  = exp_i[k];
            adc_valid = 1'b1;
            start     = glitch && (k == 100);
            @(posedge clk); #1;
            start     = 1'b0;
            adc_valid = 1'b0;
            for (int d = 1; d < duty; d++) begin
                @(posedge clk); #1;
            end
        end
        for (int e = 0; e < extra; e++) begin
            v_sample  = gen(3, 0, e);
            i_sample  = gen(3, 1, e);
            adc_valid = 1'b1;
            @(posedge clk); #1;
        end
        adc_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_feed_plus(input int offs, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (seen_feed && (cyc >= feed_cyc + offs)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------------------------------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({fft_reset, fft_ce, fft_sample, bin_valid, bin_chan, bin_idx, bin_data, busy, done, err} !== '0)
            $display("FAIL reset_outputs: got busy=%b ce=%b err=%b bin_valid=%b sample=%h expected all 0",
                     busy, fft_ce, err, bin_valid, fft_sample);
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, err, fft_ce} !== 4'b0000)
            $display("FAIL reset_idle: got busy=%b done=%b err=%b ce=%b expected 0", busy, done, err, fft_ce);
        else n_pass++;
    endtask

    task automatic test_dc();
        bit ok;
        int bad;
        clear_mon();
        // Samples offered while idle must be dropped.
        v_sample = gen(3, 0, 0); i_sample = gen(3, 1, 0); adc_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 adc_valid = 1'b0;
        pulse_start();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL dc_busy_after_start: got %b expected 1", busy); else n_pass++;
        capture(0, 1, 3, 1'b0);
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL dc_done_seen: got %b expected 1", ok); else n_pass++;
        n_checks++;
        if (bin_cnt !== FRAME_2N) $display("FAIL dc_bin_count: got %0d expected %0d", bin_cnt, FRAME_2N); else n_pass++;
        n_checks++;
        if (last_bin_cyc - first_bin_cyc + 1 !== FRAME_2N)
            $display("FAIL dc_contiguous: got span %0d expected %0d", last_bin_cyc - first_bin_cyc + 1, FRAME_2N);
        else n_pass++;
        n_checks++;
        if (first_bin_cyc - feed_cyc !== LAT + 1)
            $display("FAIL dc_first_bin_latency: got %0d expected %0d", first_bin_cyc - feed_cyc, LAT + 1);
        else n_pass++;
        n_checks++;
        if (done_cyc !== last_bin_cyc + 1) $display("FAIL dc_done_after_last: got %0d expected %0d", done_cyc, last_bin_cyc + 1);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL dc_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++;
        if (cap_cnt !== FRAME_N) $display("FAIL dc_capture_cycles: got %0d expected %0d", cap_cnt, FRAME_N); else n_pass++;
        bad = count_bad_bins();
        n_checks++;
        if (bad !== 0) $display("FAIL dc_bins: got %0d bad bins expected 0", bad); else n_pass++;
    endtask

    task automatic test_pattern();
        bit ok;
        int bad;
        clear_mon();
        pulse_start();
        capture(1, 1, 0, 1'b0);
        wait_done(ok);
        bad = count_bad_bins();
        n_checks++;
        if (bad !== 0) $display("FAIL pattern_bins: got %0d bad bins expected 0", bad); else n_pass++;
        n_checks++;
        if (ce_cnt !== done_cyc - first_ce_cyc)
            $display("FAIL pattern_ce_gapless: got %0d ce clocks expected %0d", ce_cnt, done_cyc - first_ce_cyc);
        else n_pass++;
        n_checks++;
        if (feed_cyc - first_ce_cyc !== 2)
            $display("FAIL pattern_rst_len: got %0d expected 2", feed_cyc - first_ce_cyc);
        else n_pass++;
    endtask

    task automatic test_slow_adc();
        bit ok;
        int bad;
        clear_mon();
        pulse_start();
        capture(0, 3, 0, 1'b0);
        wait_done(ok);
        n_checks++;
        if (cap_cnt !== 766) $display("FAIL slow_capture_cycles: got %0d expected 766", cap_cnt); else n_pass++;
        n_checks++;
        if (ce_cnt !== done_cyc - first_ce_cyc)
            $display("FAIL slow_ce_gapless: got %0d ce clocks expected %0d", ce_cnt, done_cyc - first_ce_cyc);
        else n_pass++;
        bad = count_bad_bins();
        n_checks++;
        if (bad !== 0) $display("FAIL slow_bins: got %0d bad bins expected 0", bad); else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int bad;
        clear_mon();
        pulse_start();
        capture(1, 1, 0, 1'b1);
        wait_feed_plus(300, ok);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ignore_busy_after_done: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++;
        if (cap_cnt !== FRAME_N) $display("FAIL ignore_capture_cycles: got %0d expected %0d", cap_cnt, FRAME_N); else n_pass++;
        bad = count_bad_bins();
        n_checks++;
        if (bad !== 0) $display("FAIL ignore_bins: got %0d bad bins expected 0", bad); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int bad, err_cyc;
        clear_mon();
        force_sync_low = 1'b1;
        pulse_start();
        capture(1, 1, 0, 1'b0);
        ok = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (err) begin
                ok = 1'b1;
                err_cyc = cyc;
                break;
            end
        end
        #1;
        n_checks++;
        if (ok !== 1'b1 || err_cyc - feed_cyc !== 2048)
            $display("FAIL timeout_err_time: got seen=%b delay=%0d expected seen=1 delay=2048", ok, err_cyc - feed_cyc);
        else n_pass++;
        n_checks++;
        if ({busy, fft_ce} !== 2'b00) $display("FAIL timeout_idle: got busy=%b ce=%b expected 0 0", busy, fft_ce); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt !== 0 || bin_cnt !== 0)
            $display("FAIL timeout_no_output: got done=%0d bins=%0d expected 0 0", done_cnt, bin_cnt);
        else n_pass++;
        n_checks++;
        if (err !== 1'b1) $display("FAIL timeout_err_sticky: got %b expected 1", err); else n_pass++;
        force_sync_low = 1'b0;
        clear_mon();
        pulse_start();
        n_checks++;
        if (err !== 1'b0) $display("FAIL timeout_err_cleared: got %b expected 0", err); else n_pass++;
        capture(2, 1, 0, 1'b0);
        wait_done(ok);
        bad = count_bad_bins();
        n_checks++;
        if (bad !== 0 || done_cnt !== 1)
            $display("FAIL timeout_recover: got %0d bad bins, done=%0d expected 0, 1", bad, done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int bad;
        clear_mon();
        pulse_start();
        capture(1, 1, 0, 1'b0);
        wait_feed_plus(300, ok);
        n_checks++;
        if ({ok, busy, bin_valid} !== 3'b111)
            $display("FAIL midrst_before: got reached=%b busy=%b bin_valid=%b expected 1 1 1", ok, busy, bin_valid);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({fft_reset, fft_ce, fft_sample, bin_valid, bin_chan, bin_idx, bin_data, busy, done, err} !== '0)
            $display("FAIL midrst_outputs: got busy=%b ce=%b bin_valid=%b sample=%h data=%h expected all 0",
                     busy, fft_ce, bin_valid, fft_sample, bin_data);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        pulse_start();
        capture(2, 1, 0, 1'b0);
        wait_done(ok);
        bad = count_bad_bins();
        n_checks++;
        if (bad !== 0) $display("FAIL midrst_new_bins: got %0d bad bins expected 0", bad); else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || bin_cnt !== FRAME_2N)
            $display("FAIL midrst_done: got done=%0d bins=%0d expected 1 %0d", done_cnt, bin_cnt, FRAME_2N);
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        adc_valid = 1'b0;
        v_sample  = '0;
        i_sample  = '0;
        clear_mon();
        test_reset();
        test_dc();
        test_pattern();
        test_slow_adc();
        test_start_ignored();
        test_timeout();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
